// File: rtl/nand_target_responder.sv
// Single-way SDR NAND target: oversampled pin decode, one page of storage, ID/status/read/program.
// Optional NTR_FAIL_INJECT_EN adds iFailInject to force FAIL on program confirm.
module nand_target_responder #(
   parameter int unsigned PageBytes       = 64,
   parameter logic [39:0] IDBytes         = 40'h2C_64_44_4B_A9,
   parameter int unsigned ReadBusyCycles  = 200,
   parameter int unsigned ProgBusyCycles  = 600,
   parameter int unsigned ResetBusyCycles = 100
) (
   input  logic       iSystemClock,
   input  logic       iModuleReset_n,
   input  logic       I_NAND_CE,
   input  logic       I_NAND_WE,
   input  logic       I_NAND_RE,
   input  logic       I_NAND_ALE,
   input  logic       I_NAND_CLE,
   input  logic       I_NAND_WP,
   input  logic [7:0] iDQFromController,
   output logic [7:0] oDQToController,
   output logic       oDQOutEnable,
   output logic       O_NAND_RB
`ifdef NTR_FAIL_INJECT_EN
   ,
   input  logic       iFailInject
`endif
);

   localparam int unsigned ColW = $clog2(PageBytes);
   typedef logic [ColW-1:0] col_t;
   typedef enum logic [2:0] {IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, ID_OUT, STATUS_OUT} state_t;
   typedef enum logic [1:0] {OP_ID, OP_READ, OP_PROG} op_t;

   // Active-low strobes reset to their idle-high level so release never looks like an edge.
   localparam logic [13:0] SyncRst = 14'h0027;

   logic [13:0] syncA, syncB;
   logic        weQ, reQ;
   logic        ceLow, weS, reS, aleS, cleS, wpS;
   logic [7:0]  dqS;
   logic        weRise, reFall, reRise, cmdStrobe, addrStrobe, dataStrobe;

   state_t      state, afterBusy;
   op_t         op;
   logic        busy, fail, dqEn;
   logic [31:0] busyCnt;
   logic [2:0]  addrCnt, addrNeed, idIdx;
   logic [7:0]  colLo, dqData, idByte;
   col_t        column;
   logic [7:0]  page [PageBytes];

   always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
      if (!iModuleReset_n) begin
         syncA <= SyncRst;
         syncB <= SyncRst;
         weQ   <= 1'b1;
         reQ   <= 1'b1;
      end else begin
         syncA <= {iDQFromController, I_NAND_WP, I_NAND_CLE, I_NAND_ALE, I_NAND_RE, I_NAND_WE, I_NAND_CE};
         syncB <= syncA;
         weQ   <= syncB[1];
         reQ   <= syncB[2];
      end
   end

   assign ceLow = ~syncB[0];
   assign weS   = syncB[1];
   assign reS   = syncB[2];
   assign aleS  = syncB[3];
   assign cleS  = syncB[4];
   assign wpS   = syncB[5];
   assign dqS   = syncB[13:6];

   assign weRise     = weS & ~weQ & ceLow;
   assign reFall     = ~reS & reQ & ceLow;
   assign reRise     = reS & ~reQ & ceLow;
   assign cmdStrobe  = weRise & cleS & ~aleS;
   assign addrStrobe = weRise & aleS & ~cleS;
   assign dataStrobe = weRise & ~aleS & ~cleS & (state == DATA_IN);

   always_comb begin
      idByte = 8'h00;
      case (idIdx)
         3'd0:    idByte = IDBytes[39:32];
         3'd1:    idByte = IDBytes[31:24];
         3'd2:    idByte = IDBytes[23:16];
         3'd3:    idByte = IDBytes[15:8];
         3'd4:    idByte = IDBytes[7:0];
         default: idByte = 8'h00;
      endcase
   end

   always_ff @(posedge iSystemClock) begin
      if (dataStrobe && wpS) page[column] <= dqS;
   end

   always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
      if (!iModuleReset_n) begin
         state     <= IDLE;
         afterBusy <= IDLE;
         op        <= OP_ID;
         busy      <= 1'b0;
         busyCnt   <= '0;
         addrCnt   <= '0;
         addrNeed  <= '0;
         idIdx     <= '0;
         colLo     <= '0;
         column    <= '0;
         fail      <= 1'b0;
         dqData    <= '0;
         dqEn      <= 1'b0;
      end else begin
         // The busy timer runs independently of state so a status read cannot stall it.
         if (busy) begin
            if (busyCnt == '0) begin
               busy <= 1'b0;
               if (state == BUSY) state <= afterBusy;
            end else begin
               busyCnt <= busyCnt - 32'd1;
            end
         end

         if (!ceLow) begin
            dqEn <= 1'b0;
            if (state != BUSY && state != IDLE) state <= IDLE;
         end else if (cmdStrobe) begin
            if (dqS == 8'hFF) begin
               state     <= BUSY;
               afterBusy <= IDLE;
               busy      <= 1'b1;
               busyCnt   <= ResetBusyCycles - 1;
               column    <= '0;
               fail      <= 1'b0;
               dqEn      <= 1'b0;
            end else if (dqS == 8'h70) begin
               state <= STATUS_OUT;
            end else if (!busy) begin
               case (dqS)
                  8'h90: begin state <= ADDR; op <= OP_ID;   addrNeed <= 3'd1; addrCnt <= '0; end
                  8'h00: begin state <= ADDR; op <= OP_READ; addrNeed <= 3'd5; addrCnt <= '0; end
                  8'h80: begin state <= ADDR; op <= OP_PROG; addrNeed <= 3'd5; addrCnt <= '0; end
                  8'h30: if (state == ADDR && op == OP_READ) begin
                     state     <= BUSY;
                     afterBusy <= DATA_OUT;
                     busy      <= 1'b1;
                     busyCnt   <= ReadBusyCycles - 1;
                  end
                  8'h10: if (state == DATA_IN) begin
                     state     <= BUSY;
                     afterBusy <= IDLE;
                     busy      <= 1'b1;
                     busyCnt   <= ProgBusyCycles - 1;
`ifdef NTR_FAIL_INJECT_EN
                     fail      <= ~wpS | iFailInject;
`else
                     fail      <= ~wpS;
`endif
                  end
                  default: ;
               endcase
            end
         end else if (addrStrobe && state == ADDR && addrCnt < addrNeed) begin
            addrCnt <= addrCnt + 3'd1;
            if (addrCnt == 3'd0) begin
               colLo  <= dqS;
               column <= col_t'(dqS);
            end else if (addrCnt == 3'd1) begin
               column <= col_t'({dqS, colLo});
            end
            if (addrCnt + 3'd1 == addrNeed) begin
               if (op == OP_ID) begin
                  state <= ID_OUT;
                  idIdx <= '0;
               end else if (op == OP_PROG) begin
                  state <= DATA_IN;
               end
            end
         end else if (dataStrobe) begin
            column <= column + col_t'(1);
         end else if (reFall) begin
            case (state)
               DATA_OUT:   begin dqData <= page[column]; dqEn <= 1'b1; end
               ID_OUT:     begin dqData <= idByte;       dqEn <= 1'b1; end
               STATUS_OUT: begin dqData <= {wpS, ~busy, ~busy, 4'b0000, fail}; dqEn <= 1'b1; end
               default: ;
            endcase
         end else if (reRise) begin
            dqEn <= 1'b0;
            if (state == DATA_OUT) column <= column + col_t'(1);
            if (state == ID_OUT && idIdx < 3'd5) idIdx <= idIdx + 3'd1;
         end
      end
   end

   // Output stage; CE gating uses the synchronized pin directly so release is not delayed by the FSM.
   always_ff @(posedge iSystemClock or negedge iModuleReset_n) begin
      if (!iModuleReset_n) begin
         oDQToController <= 8'h00;
         oDQOutEnable    <= 1'b0;
         O_NAND_RB       <= 1'b1;
      end else begin
         oDQToController <= dqData;
         oDQOutEnable    <= dqEn & ceLow;
         O_NAND_RB       <= ~busy;
      end
   end

endmodule

// File: tb/tb_nand_target_responder.sv
// Directed bench for nand_target_responder: ID, program/read, wrap, WP, abort, CE release and reset.
module tb_nand_target_responder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ce = 1'b1, we = 1'b1, re = 1'b1, ale = 1'b0, cle = 1'b0, wp = 1'b1;
   logic [7:0] dqIn = 8'h00;
   logic [7:0] dqOut;
   logic       oe, rb;
   logic       failInject = 1'b0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   nand_target_responder dut (
      .iSystemClock     (clk),
      .iModuleReset_n   (rst_n),
      .I_NAND_CE        (ce),
      .I_NAND_WE        (we),
      .I_NAND_RE        (re),
      .I_NAND_ALE       (ale),
      .I_NAND_CLE       (cle),
      .I_NAND_WP        (wp),
      .iDQFromController(dqIn),
      .oDQToController  (dqOut),
      .oDQOutEnable     (oe),
      .O_NAND_RB        (rb)
`ifdef NTR_FAIL_INJECT_EN
      ,
      .iFailInject      (failInject)
`endif
   );

   task automatic busCycle(input logic c, input logic a, input logic [7:0] b);
      ce = 1'b0; cle = c; ale = a; dqIn = b;
      @(negedge clk); we = 1'b0;
      repeat (3) @(negedge clk);
      we = 1'b1;
      repeat (4) @(negedge clk);
      cle = 1'b0; ale = 1'b0;
   endtask

   task automatic sendAddr5(input logic [7:0] colLo);
      busCycle(1'b0, 1'b1, colLo);
      for (int unsigned i = 0; i < 4; i++) busCycle(1'b0, 1'b1, 8'h00);
   endtask

   // Confirm command: samples RB just before/at its expected fall, then counts busy cycles.
   task automatic confirmCycle(input logic [7:0] b, input int maxN,
                               output logic rb3, output logic rb4, output int lowCnt);
      ce = 1'b0; cle = 1'b1; ale = 1'b0; dqIn = b;
      @(negedge clk); we = 1'b0;
      repeat (3) @(negedge clk);
      we = 1'b1;
      repeat (3) @(negedge clk);
      rb3 = rb;
      @(negedge clk);
      rb4 = rb;
      cle = 1'b0;
      lowCnt = (rb4 === 1'b0) ? 1 : 0;
      while (lowCnt > 0 && lowCnt <= maxN) begin
         @(negedge clk);
         if (rb !== 1'b0) break;
         lowCnt++;
      end
   endtask

   task automatic reCycle(output logic [7:0] d, output logic oeEarly, output logic oeOn, output logic oeOff);
      re = 1'b0;
      repeat (3) @(negedge clk);
      oeEarly = oe;
      @(negedge clk);
      oeOn = oe;
      d = dqOut;
      re = 1'b1;
      repeat (4) @(negedge clk);
      oeOff = oe;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (rb !== 1'b1) begin failures++; $display("FAIL reset_rb got=%b exp=1", rb); end
      checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", oe); end
      checks++; if (dqOut !== 8'h00) begin failures++; $display("FAIL reset_dq got=%h exp=00", dqOut); end
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (rb !== 1'b1 || oe !== 1'b0) begin failures++; $display("FAIL post_reset_idle got rb=%b oe=%b exp rb=1 oe=0", rb, oe); end
   endtask

   task automatic test_read_id;
      logic [7:0] exp [6];
      logic [7:0] d;
      logic e0, e1, e2;
      exp = '{8'h2C, 8'h64, 8'h44, 8'h4B, 8'hA9, 8'h00};
      busCycle(1'b1, 1'b0, 8'h90);
      busCycle(1'b0, 1'b1, 8'h00);
      for (int unsigned i = 0; i < 6; i++) begin
         reCycle(d, e0, e1, e2);
         checks++; if (d !== exp[i]) begin failures++; $display("FAIL id_byte%0d got=%h exp=%h", i, d, exp[i]); end
         checks++; if (e1 !== 1'b1) begin failures++; $display("FAIL id_oe_on%0d got=%b exp=1", i, e1); end
         if (i == 0) begin
            checks++; if (e0 !== 1'b0) begin failures++; $display("FAIL id_oe_early got=%b exp=0", e0); end
            checks++; if (e2 !== 1'b0) begin failures++; $display("FAIL id_oe_off got=%b exp=0", e2); end
         end
      end
      checks++; if (rb !== 1'b1) begin failures++; $display("FAIL id_rb got=%b exp=1", rb); end
   endtask

   task automatic test_unknown_cmd;
      logic [7:0] d;
      logic e0, e1, e2;
      busCycle(1'b1, 1'b0, 8'h90);
      busCycle(1'b0, 1'b1, 8'h00);
      busCycle(1'b1, 1'b0, 8'h55);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h2C || e1 !== 1'b1) begin failures++; $display("FAIL unknown_cmd got=%h oe=%b exp=2C oe=1", d, e1); end
   endtask

   task automatic test_program;
      logic [7:0] d;
      logic e0, e1, e2, r3, r4;
      int n;
      wp = 1'b1;
      busCycle(1'b1, 1'b0, 8'h80);
      sendAddr5(8'h00);
      busCycle(1'b0, 1'b0, 8'h11);
      busCycle(1'b0, 1'b0, 8'h22);
      busCycle(1'b0, 1'b0, 8'h33);
      confirmCycle(8'h10, 700, r3, r4, n);
      checks++; if (r3 !== 1'b1) begin failures++; $display("FAIL prog_rb_early got=%b exp=1", r3); end
      checks++; if (r4 !== 1'b0) begin failures++; $display("FAIL prog_rb_fall got=%b exp=0", r4); end
      checks++; if (n != 600) begin failures++; $display("FAIL prog_busy_len got=%0d exp=600", n); end
      busCycle(1'b1, 1'b0, 8'h70);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'hE0) begin failures++; $display("FAIL prog_status got=%h exp=E0", d); end
   endtask

   task automatic test_read;
      logic [7:0] d;
      logic e0, e1, e2, r3, r4;
      int n;
      busCycle(1'b1, 1'b0, 8'h00);
      sendAddr5(8'h01);
      confirmCycle(8'h30, 300, r3, r4, n);
      checks++; if (r4 !== 1'b0 || n != 200) begin failures++; $display("FAIL read_busy_len got=%0d fall=%b exp=200 fall=0", n, r4); end
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h22) begin failures++; $display("FAIL read_byte0 got=%h exp=22", d); end
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h33) begin failures++; $display("FAIL read_byte1 got=%h exp=33", d); end
   endtask

   task automatic test_wrap_wp;
      logic [7:0] d;
      logic e0, e1, e2, r3, r4;
      int n;
      wp = 1'b0;
      repeat (4) @(negedge clk);
      busCycle(1'b1, 1'b0, 8'h80);
      sendAddr5(8'h3F);
      busCycle(1'b0, 1'b0, 8'hAA);
      busCycle(1'b0, 1'b0, 8'hBB);
      confirmCycle(8'h10, 700, r3, r4, n);
      checks++; if (n != 600) begin failures++; $display("FAIL wp_busy_len got=%0d exp=600", n); end
      busCycle(1'b1, 1'b0, 8'h70);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h61) begin failures++; $display("FAIL wp_status got=%h exp=61", d); end
      busCycle(1'b1, 1'b0, 8'h00);
      sendAddr5(8'h00);
      confirmCycle(8'h30, 300, r3, r4, n);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h11) begin failures++; $display("FAIL wp_page_kept got=%h exp=11", d); end
      wp = 1'b1;
      repeat (4) @(negedge clk);
      busCycle(1'b1, 1'b0, 8'h80);
      sendAddr5(8'h3F);
      busCycle(1'b0, 1'b0, 8'hAA);
      busCycle(1'b0, 1'b0, 8'hBB);
      confirmCycle(8'h10, 700, r3, r4, n);
      busCycle(1'b1, 1'b0, 8'h70);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'hE0) begin failures++; $display("FAIL wrap_status got=%h exp=E0", d); end
      busCycle(1'b1, 1'b0, 8'h00);
      sendAddr5(8'h3F);
      confirmCycle(8'h30, 300, r3, r4, n);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'hAA) begin failures++; $display("FAIL wrap_byte63 got=%h exp=AA", d); end
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'hBB) begin failures++; $display("FAIL wrap_byte0 got=%h exp=BB", d); end
   endtask

   task automatic test_abort;
      logic [7:0] d;
      logic e0, e1, e2, r3, r4;
      int n;
      wp = 1'b1;
      busCycle(1'b1, 1'b0, 8'h80);
      sendAddr5(8'h00);
      busCycle(1'b1, 1'b0, 8'h10);
      repeat (20) @(negedge clk);
      busCycle(1'b1, 1'b0, 8'h70);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'h80) begin failures++; $display("FAIL status_busy got=%h exp=80", d); end
      checks++; if (rb !== 1'b0) begin failures++; $display("FAIL abort_rb_busy got=%b exp=0", rb); end
      confirmCycle(8'hFF, 200, r3, r4, n);
      checks++; if (r3 !== 1'b0) begin failures++; $display("FAIL abort_rb_held got=%b exp=0", r3); end
      checks++; if (n != 100) begin failures++; $display("FAIL abort_busy_len got=%0d exp=100", n); end
      busCycle(1'b1, 1'b0, 8'h70);
      reCycle(d, e0, e1, e2);
      checks++; if (d !== 8'hE0) begin failures++; $display("FAIL abort_status got=%h exp=E0", d); end
   endtask

   task automatic test_ce_high;
      logic [7:0] d;
      logic e0, e1, e2;
      busCycle(1'b1, 1'b0, 8'h90);
      busCycle(1'b0, 1'b1, 8'h00);
      re = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (oe !== 1'b1) begin failures++; $display("FAIL ce_pre_oe got=%b exp=1", oe); end
      ce = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (oe !== 1'b0) begin failures++; $display("FAIL ce_release_oe got=%b exp=0", oe); end
      re = 1'b1;
      repeat (4) @(negedge clk);
      ce = 1'b0;
      repeat (4) @(negedge clk);
      reCycle(d, e0, e1, e2);
      checks++; if (e1 !== 1'b0) begin failures++; $display("FAIL ce_idle_no_drive got=%b exp=0", e1); end
   endtask

   task automatic test_reset_mid;
      logic r3, r4;
      int n;
      busCycle(1'b1, 1'b0, 8'h00);
      sendAddr5(8'h00);
      busCycle(1'b1, 1'b0, 8'h30);
      repeat (10) @(negedge clk);
      checks++; if (rb !== 1'b0) begin failures++; $display("FAIL mid_rb_busy got=%b exp=0", rb); end
      rst_n = 1'b0;
      #1;
      checks++; if (rb !== 1'b1) begin failures++; $display("FAIL mid_reset_rb got=%b exp=1", rb); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      busCycle(1'b1, 1'b0, 8'h00);
      sendAddr5(8'h00);
      confirmCycle(8'h30, 300, r3, r4, n);
      re = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (oe !== 1'b1 || dqOut !== 8'hBB) begin failures++; $display("FAIL mid_read_drive got oe=%b dq=%h exp oe=1 dq=BB", oe, dqOut); end
      rst_n = 1'b0;
      #1;
      checks++; if (oe !== 1'b0 || dqOut !== 8'h00 || rb !== 1'b1) begin failures++; $display("FAIL mid_reset_out got oe=%b dq=%h rb=%b exp oe=0 dq=00 rb=1", oe, dqOut, rb); end
      re = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_read_id();
      test_unknown_cmd();
      test_program();
      test_read();
      test_wrap_wp();
      test_abort();
      test_ce_high();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/nand_target_responder.md
# nand_target_responder

Synthesizable single-way NAND target that answers the controller's PHY pins in SDR (asynchronous-interface) mode. Used for FPGA loopback and for bring-up of the controller PHY/ACG path without a real device. It oversamples CE/WE/RE/ALE/CLE on its own clock and decodes a subset of ONFI commands: reset, read ID, read status, page read, page program. It holds one page of storage, drives DQ on read cycles, and drives R/B with programmable busy times.

## Interface
- PageBytes, 64: page size in bytes; power of two, 16..4096.
- IDBytes, 40'h2C_64_44_4B_A9: 5-byte ID, MSB byte returned first.
- ReadBusyCycles, 200: tR in clock cycles.
- ProgBusyCycles, 600: tPROG in clock cycles.
- ResetBusyCycles, 100: tRST in clock cycles.
- iSystemClock  in  1  sampling clock, at least 4x the WE/RE toggle rate.
- iModuleReset_n  in  1  asynchronous, active-low reset.
- I_NAND_CE  in  1  chip enable, active low.
- I_NAND_WE  in  1  write enable, active low; latch on rising edge.
- I_NAND_RE  in  1  read enable, active low.
- I_NAND_ALE  in  1  address latch enable.
- I_NAND_CLE  in  1  command latch enable.
- I_NAND_WP  in  1  write protect, active low.
- iDQFromController  in  8  DQ pad input.
- oDQToController  out  8  DQ pad output data.
- oDQOutEnable  out  1  DQ pad drive enable.
- O_NAND_RB  out  1  ready(1)/busy(0).

## Operation
- All pin inputs pass a 2-flop synchronizer, then a 1-flop edge detector.
- WE rising edge with CE low: CLE=1,ALE=0 → command; ALE=1,CLE=0 → address byte; both 0 in DATA_IN → data byte; both 1 → ignored.
- States: IDLE, ADDR, DATA_IN, BUSY, DATA_OUT, ID_OUT, STATUS_OUT.
- 0xFF (any state): abort, column=0, FAIL=0, → BUSY for ResetBusyCycles, then IDLE.
- 0x90: → ADDR expecting 1 byte; then ID_OUT, byte index 0.
- 0x70: → STATUS_OUT; the only command besides 0xFF accepted in BUSY. BUSY countdown continues; after it expires from STATUS_OUT, state stays STATUS_OUT.
- 0x00: → ADDR expecting 5 bytes (col lo, col hi, row×3; row ignored); 0x30 → BUSY for ReadBusyCycles, then DATA_OUT.
- 0x80: → ADDR expecting 5 bytes, then DATA_IN. Each data byte written to page[column] unless WP low; column increments. 0x10 → BUSY for ProgBusyCycles, then IDLE. FAIL set if WP was low at 0x10.
- Column = {col hi, col lo} modulo PageBytes; increments wrap to 0. Address bytes beyond the expected count are ignored.
- Unknown commands are ignored; state unchanged.
- Output: RE falling edge in DATA_OUT/ID_OUT/STATUS_OUT → load oDQToController, oDQOutEnable=1. RE rising edge → oDQOutEnable=0, advance the index (column or ID index). Status is not advanced.
- ID_OUT: bytes 0..4 from IDBytes; index ≥5 returns 0x00.
- Status byte: {WP pin, RDY, RDY, 4'b0, FAIL}; RDY = ~busy.
- CE high: oDQOutEnable=0 within 3 cycles; ADDR/DATA_IN/DATA_OUT/ID_OUT/STATUS_OUT → IDLE; BUSY continues.

## Timing
- Reset values: O_NAND_RB=1, oDQOutEnable=0, oDQToController=8'h00, FAIL=0, column=0, state IDLE. Page contents are undefined.
- Pin edge to internal action: 3 cycles (sync 2 + detect 1).
- O_NAND_RB falls 1 cycle after the confirm command (0x30/0x10/0xFF) is latched. It rises exactly N cycles later, N = the relevant busy parameter.
- DQ valid and oDQOutEnable high: 4 cycles after the RE falling pin edge. Disable: 4 cycles after the RE rising pin edge.
- 0xFF during BUSY restarts the countdown with ResetBusyCycles.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous).

## Configuration
- NTR_FAIL_INJECT_EN defined: adds port iFailInject (in, 1). If iFailInject is high at 0x10 latch, FAIL=1 and data written during that DATA_IN is still kept.
- Undefined: port absent; FAIL is set only by WP.

## Test plan
- Read ID: 0x90, addr 0x00, 6 RE pulses → 2C,64,44,4B,A9,00; RB stays 1.
- Program: 0x80, addr 00 00 00 00 00, data 11,22,33, 0x10 with WP=1 → RB low exactly 600 cycles; 0x70 → status 0xE0 once ready, 0x80 while busy.
- Read: 0x00, addr 01 00 00 00 00, 0x30 → RB low 200 cycles; 2 RE pulses → 22,33.
- Wrap and WP: program col 63 with bytes AA,BB and WP=0 → page unchanged, status 0x61. Repeat with WP=1, then read from col 63 → AA,BB (column wrapped to 0).
- Reset abort: 0xFF issued 50 cycles into tPROG → RB stays low 100 further cycles, status 0xE0; asserting iModuleReset_n mid-read → oDQOutEnable=0, RB=1 immediately.
